// File: rtl/piso_stream_serializer.sv
// piso_stream_serializer
// Parallel-to-serial converter with a valid/ready load handshake, downstream
// backpressure, selectable bit order and a one-word holding buffer so that
// back-to-back words leave the serial port with no idle bit between them.
`timescale 1ns/1ps

module piso_stream_serializer #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] parallel_i,
    output logic              serial_o,
    output logic              valid_o,
    input  logic              ser_ready_i,
    output logic              last_o,
    output logic              empty_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    // One-hot style encoding so that corrupted values are detectable and
    // steered back to IDLE by the default branch of the next-state logic.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_SHIFT = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [DATA_W-1:0]   shift_r;
    logic [DATA_W-1:0]   shift_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nx_s;
    logic [DATA_W-1:0]   hold_r;
    logic [DATA_W-1:0]   hold_nx_s;
    logic                hold_v_r;
    logic                hold_v_nx_s;

    logic                valid_s;
    logic                accept_s;
    logic                xfer_s;
    logic                at_last_s;
    logic                last_xfer_s;
    logic [CNT_W-1:0]    sel_s;

    // Handshake events derived from registered state and the live inputs.
    always_comb begin
        valid_s     = (state_r == ST_SHIFT);
        accept_s    = load_valid_i & ~hold_v_r;
        xfer_s      = valid_s & ser_ready_i;
        at_last_s   = (cnt_r == LAST_CNT);
        last_xfer_s = xfer_s & at_last_s;
    end

    // State and datapath registers with synchronous reset that drops any word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            shift_r  <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            hold_r   <= {DATA_W{1'b0}};
            hold_v_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            shift_r  <= shift_nx_s;
            cnt_r    <= cnt_nx_s;
            hold_r   <= hold_nx_s;
            hold_v_r <= hold_v_nx_s;
        end
    end

    // Next-state logic: loading, bit advance, last-bit refill and buffering.
    always_comb begin
        state_nx_s  = state_r;
        shift_nx_s  = shift_r;
        cnt_nx_s    = cnt_r;
        hold_nx_s   = hold_r;
        hold_v_nx_s = hold_v_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_nx_s = parallel_i;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (xfer_s && !at_last_s) begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end else if (last_xfer_s) begin
                    // Refill priority: buffered word, then same-cycle bypass.
                    if (hold_v_r) begin
                        shift_nx_s  = hold_r;
                        cnt_nx_s    = {CNT_W{1'b0}};
                        hold_v_nx_s = 1'b0;
                    end else if (accept_s) begin
                        shift_nx_s = parallel_i;
                        cnt_nx_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    cnt_nx_s = cnt_r;
                end

                // A word arriving while the shifter is busy waits in the buffer.
                if (accept_s && !last_xfer_s) begin
                    hold_nx_s   = parallel_i;
                    hold_v_nx_s = 1'b1;
                end else begin
                    hold_nx_s = hold_nx_s;
                end
            end
            default: begin
                state_nx_s  = ST_IDLE;
                cnt_nx_s    = {CNT_W{1'b0}};
                hold_v_nx_s = 1'b0;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        if (LSB_FIRST) begin
            sel_s = cnt_r;
        end else begin
            sel_s = LAST_CNT - cnt_r;
        end
        valid_o      = valid_s;
        serial_o     = valid_s ? shift_r[sel_s] : 1'b0;
        last_o       = valid_s & at_last_s;
        empty_o      = (state_r == ST_IDLE) & ~hold_v_r;
        load_ready_o = ~hold_v_r;
    end

endmodule
